// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared helpers and constants for the async FIFO pointer
//                blocks on both the write and the read side.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Flop stages in each pointer synchroniser, shared by both sides.
    localparam int c_SYNC_STAGES = 2;

    // Binary to Gray. Narrower values are zero-extended by the caller, which
    // leaves the low bits of the result identical to a narrow conversion.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary, XOR prefix from the MSB down. Zero-extended inputs
    // contribute nothing above their width, so any width up to 32 works.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b     = '0;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/wptr_full_level_gray2bin_conv.sv
`default_nettype none
// ============================================================================
//  Module      : gray2bin_conv
//  Description : Purely combinational Gray-to-binary converter of width W.
//                Shared by the write-side and read-side level generators.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        bin_o      = '0;
        bin_o[W-1] = gray_i[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            bin_o[i] = bin_o[i+1] ^ gray_i[i];
        end
    end

endmodule : gray2bin_conv
`default_nettype wire

// File: rtl/wptr_full_level.sv
`default_nettype none
// ============================================================================
//  Module      : wptr_full_level
//  Description : Write-side pointer and flag generator for the async FIFO.
//                Keeps binary/Gray write pointers, RAM write address and a
//                registered full flag, plus fill level, programmable
//                almost-full and a sticky overflow flag. wclk domain only.
//  Revision    : 1.0 - initial release
// ============================================================================
module wptr_full_level
    import fifo_pkg::*;
#(
    parameter int ADD_SIZE = 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADD_SIZE:0]   wq2_rptr,
    input  logic [ADD_SIZE:0]   wafull_lvl,
    input  logic                wclr_ovf,
    output logic [ADD_SIZE-1:0] waddr,
    output logic [ADD_SIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADD_SIZE:0]   wlevel,
    output logic                wovf
);

    // Pointer width carries one extra wrap bit over the RAM address.
    localparam int c_PW = ADD_SIZE + 1;

    logic [ADD_SIZE:0] wbin_q,   wbin_d;
    logic [ADD_SIZE:0] wptr_q,   wptr_d;
    logic [ADD_SIZE:0] wlevel_q, wlevel_d;
    logic              wfull_q,  wfull_d;
    logic              wafull_q, wafull_d;
    logic              wovf_q,   wovf_d;

    logic              w_acc;
    logic [ADD_SIZE:0] w_rbin;
    logic [ADD_SIZE:0] w_full_cmp;

    // Synchronised read pointer back to binary for the level subtraction.
    gray2bin_conv #(
        .W (c_PW)
    ) u_rptr_conv (
        .gray_i (wq2_rptr),
        .bin_o  (w_rbin)
    );

    // Full pattern: read pointer with its two MSBs inverted, i.e. exactly
    // one full lap (DEPTH words) behind the next write pointer.
    assign w_full_cmp = {~wq2_rptr[ADD_SIZE:ADD_SIZE-1], wq2_rptr[ADD_SIZE-2:0]};

    // Next-state for pointers and all flags; level is taken from the next
    // write pointer so the flags agree with the pointer loaded on this edge.
    always_comb begin
        w_acc    = winc & ~wfull_q;
        wbin_d   = wbin_q + c_PW'(w_acc);
        wptr_d   = c_PW'(bin2gray(32'(wbin_d)));
        wfull_d  = (wptr_d == w_full_cmp);
        wlevel_d = wbin_d - w_rbin;
        wafull_d = (wlevel_d >= wafull_lvl);
        // A rejected write sets the flag even if a clear arrives with it.
        wovf_d   = (winc & wfull_q) | (wovf_q & ~wclr_ovf);
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr  = wbin_q[ADD_SIZE-1:0];
    assign wptr   = wptr_q;
    assign wfull  = wfull_q;
    assign wafull = wafull_q;
    assign wlevel = wlevel_q;
    assign wovf   = wovf_q;

endmodule : wptr_full_level
`default_nettype wire

// File: tb/tb_wptr_full_level.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wptr_full_level
//  Description : Self-checking bench for wptr_full_level (ADD_SIZE = 4).
//                Reference model tracks total words written and read as
//                plain integers; occupancy is their difference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wptr_full_level;

    localparam int c_AS    = 4;
    localparam int c_DEPTH = 16;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic       wclr_ovf;
    logic [4:0] wq2_rptr;
    logic [4:0] wafull_lvl;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       wafull;
    logic [4:0] wlevel;
    logic       wovf;

    int checks = 0;
    int errors = 0;

    // Reference model state: totals since reset, never wrapped.
    int m_wr, m_rd, m_level;
    bit m_full, m_afull, m_ovf;

    wptr_full_level #(.ADD_SIZE(c_AS)) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .winc       (winc),
        .wq2_rptr   (wq2_rptr),
        .wafull_lvl (wafull_lvl),
        .wclr_ovf   (wclr_ovf),
        .waddr      (waddr),
        .wptr       (wptr),
        .wfull      (wfull),
        .wafull     (wafull),
        .wlevel     (wlevel),
        .wovf       (wovf)
    );

    always #5 wclk = ~wclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [4:0] g5(input int v);
        int b;
        b = v % 32;
        return 5'(b ^ (b >> 1));
    endfunction

    function automatic logic [16:0] exp_vec();
        return {4'(m_wr % c_DEPTH), g5(m_wr), m_full, m_afull, 5'(m_level), m_ovf};
    endfunction

    function automatic logic [16:0] act_vec();
        return {waddr, wptr, wfull, wafull, wlevel, wovf};
    endfunction

    // Advance the model by one write-clock edge and wait past that edge.
    task automatic tick();
        bit acc;
        wq2_rptr = g5(m_rd);
        acc      = winc && !m_full;
        m_ovf    = (winc && m_full) || (m_ovf && !wclr_ovf);
        m_wr     = m_wr + int'(acc);
        m_level  = m_wr - m_rd;
        m_full   = (m_level == c_DEPTH);
        m_afull  = (m_level >= int'(wafull_lvl));
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge wclk);
        #1;
        winc = 0; wclr_ovf = 0; wq2_rptr = '0;
        wrst_n = 0;
        m_wr = 0; m_rd = 0; m_level = 0;
        m_full = 0; m_afull = 0; m_ovf = 0;
        #2;
        wrst_n = 1;
    endtask

    task automatic test_reset();
        wafull_lvl = 5'd14;
        do_reset();
        checks++;
        if (act_vec() !== 17'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", act_vec(), 17'h0);
        end
        winc = 1;
        repeat (5) tick();
        winc = 0;
        checks++;
        if (wlevel !== 5'd5) begin
            errors++;
            $display("FAIL pre_reset_level: got %0d expected 5", wlevel);
        end
        // Assert reset away from any clock edge; outputs must clear at once.
        #2;
        wrst_n = 0;
        #1;
        checks++;
        if (act_vec() !== 17'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", act_vec(), 17'h0);
        end
        wrst_n = 1;
        m_wr = 0; m_rd = 0; m_level = 0;
        m_full = 0; m_afull = 0; m_ovf = 0;
    endtask

    task automatic test_fill();
        wafull_lvl = 5'd14;
        do_reset();
        m_rd = 0;
        winc = 1;
        for (int i = 1; i <= c_DEPTH; i++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fill_step%0d: got %h expected %h", i, act_vec(), exp_vec());
            end
            if (i == 14) begin
                checks++;
                if (wlevel !== 5'd14 || wafull !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_afull14: got level=%0d afull=%b expected 14/1", wlevel, wafull);
                end
            end
        end
        winc = 0;
        checks++;
        if (wlevel !== 5'd16 || wfull !== 1'b1 || wptr !== 5'b11000 || waddr !== 4'd0) begin
            errors++;
            $display("FAIL fill_full16: got level=%0d full=%b wptr=%b waddr=%0d expected 16/1/11000/0",
                     wlevel, wfull, wptr, waddr);
        end
    endtask

    task automatic test_overflow();
        winc = 1;
        tick();
        winc = 0;
        checks++;
        if (wptr !== 5'b11000 || wovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got wptr=%b ovf=%b expected 11000/1", wptr, wovf);
        end
        winc = 1; wclr_ovf = 1;
        tick();
        checks++;
        if (wovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b expected 1", wovf);
        end
        winc = 0;
        tick();
        wclr_ovf = 0;
        checks++;
        if (wovf !== 1'b0 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ovf_clear: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_release();
        m_rd = 4;
        winc = 1;
        tick();
        checks++;
        if (wfull !== 1'b0 || wlevel !== 5'd12 || wafull !== 1'b0 || wptr !== 5'b11000) begin
            errors++;
            $display("FAIL release: got full=%b level=%0d afull=%b wptr=%b expected 0/12/0/11000",
                     wfull, wlevel, wafull, wptr);
        end
        tick();
        winc = 0;
        checks++;
        if (wlevel !== 5'd13 || wptr !== 5'b11001 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL retry_write: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_wrap();
        int          hist[$];
        int          cyc;
        bit          saw_wrap;
        logic [4:0]  prev;
        wafull_lvl = 5'($urandom_range(0, 3));
        do_reset();
        cyc = 0;
        saw_wrap = 0;
        while (m_wr < 40 && cyc < 300) begin
            winc = ($urandom_range(0, 3) != 0);
            hist.push_back(m_wr);
            if (hist.size() > 2) m_rd = hist.pop_front();
            prev = wptr;
            tick();
            cyc++;
            checks++;
            if (act_vec() !== exp_vec() || wlevel > 5'd16 || $countones(prev ^ wptr) > 1) begin
                errors++;
                $display("FAIL wrap_cycle%0d: got %h expected %h prev_wptr=%b", cyc, act_vec(), exp_vec(), prev);
            end
            if (prev == 5'b10000 && wptr == 5'b00000) saw_wrap = 1;
        end
        winc = 0;
        checks++;
        if (m_wr < 40 || !saw_wrap) begin
            errors++;
            $display("FAIL wrap_done: got writes=%0d wrap=%b expected >=40/1", m_wr, saw_wrap);
        end
    endtask

    task automatic test_random();
        logic [4:0] prev;
        wafull_lvl = 5'($urandom_range(0, 17));
        do_reset();
        for (int c = 0; c < 400; c++) begin
            winc     = ($urandom_range(0, 2) != 0);
            wclr_ovf = ($urandom_range(0, 7) == 0);
            if (m_rd < m_wr && $urandom_range(0, 2) == 0) m_rd++;
            prev = wptr;
            tick();
            checks++;
            if (act_vec() !== exp_vec() || $countones(prev ^ wptr) > 1) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h lvl=%0d", c, act_vec(), exp_vec(), wafull_lvl);
            end
        end
        winc = 0; wclr_ovf = 0;
    endtask

    task automatic test_thresholds();
        int bad;
        wafull_lvl = 5'd0;
        do_reset();
        checks++;
        if (wafull !== 1'b0) begin
            errors++;
            $display("FAIL lvl0_reset: got %b expected 0", wafull);
        end
        tick();
        checks++;
        if (wafull !== 1'b1) begin
            errors++;
            $display("FAIL lvl0_first_edge: got %b expected 1", wafull);
        end
        wafull_lvl = 5'd17;
        do_reset();
        bad = 0;
        winc = 1;
        repeat (c_DEPTH + 2) begin
            tick();
            if (wafull !== 1'b0) bad++;
        end
        winc = 0;
        checks++;
        if (bad != 0 || wfull !== 1'b1 || wlevel !== 5'd16) begin
            errors++;
            $display("FAIL lvl17_never: got afull_cycles=%0d full=%b level=%0d expected 0/1/16", bad, wfull, wlevel);
        end
    endtask

    initial begin
        wrst_n = 0; winc = 0; wclr_ovf = 0;
        wq2_rptr = '0; wafull_lvl = 5'd14;
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
        test_random();
        test_thresholds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wptr_full_level
`default_nettype wire

// File: doc/wptr_full_level.md
Name: wptr_full_level

Overview:
Write-side pointer and flag generator for the async FIFO, successor to the basic write-pointer/full block. It keeps the binary and Gray write pointers, the RAM write address and a registered full flag. It also adds a fill-level count, a runtime-programmable almost-full flag and a sticky overflow flag. It sits in the wclk domain; the 2-flop synchronised read pointer arrives from the existing sync block.

Parameters:
ADD_SIZE, 4, RAM address width; DEPTH = 2**ADD_SIZE; must be >= 2.

Ports:
wclk  input  1  write clock
wrst_n  input  1  reset, asynchronous, active-low
winc  input  1  write request
wq2_rptr  input  ADD_SIZE+1  read pointer (Gray) synchronised into wclk
wafull_lvl  input  ADD_SIZE+1  almost-full threshold, in words (quasi-static)
wclr_ovf  input  1  clears sticky overflow flag
waddr  output  ADD_SIZE  RAM write address
wptr  output  ADD_SIZE+1  Gray write pointer, to the read-side synchroniser
wfull  output  1  FIFO full
wafull  output  1  fill level >= wafull_lvl
wlevel  output  ADD_SIZE+1  words held, as seen from the write side (0..DEPTH)
wovf  output  1  sticky: a write was attempted while full

Behaviour:
- Reset (wrst_n low, async): wbin, wptr, wfull, wafull, wlevel and wovf are all 0; waddr = 0.
- Accept: wacc = winc & ~wfull. wbin_next = wbin + wacc, modulo 2**(ADD_SIZE+1), so it wraps naturally. wgray_next = wbin_next ^ (wbin_next >> 1).
- Registers on each wclk edge: wbin <= wbin_next; wptr <= wgray_next.
- waddr = wbin[ADD_SIZE-1:0], combinational from the register.
- Full: wfull <= (wgray_next == {~wq2_rptr[ADD_SIZE:ADD_SIZE-1], wq2_rptr[ADD_SIZE-2:0]}). Registered; asserts on the same edge that accepts the DEPTH-th outstanding word.
- Level: rbin = gray-to-binary(wq2_rptr). wlevel <= (wbin_next - rbin) mod 2**(ADD_SIZE+1). The value is always in 0..DEPTH.
- Level is pessimistic: the read pointer lags by the sync latency, so wlevel never under-reports occupancy.
- Almost-full: wafull <= (level_next >= wafull_lvl), where level_next is the value loaded into wlevel on the same edge.
  - wafull_lvl = 0: wafull is 1 from the first edge after reset.
  - wafull_lvl > DEPTH: wafull never asserts.
  - wafull_lvl = DEPTH: wafull tracks wfull.
- Flag release: wfull, wafull and wlevel update one edge after a new wq2_rptr value arrives. No extra latency beyond the external synchroniser.
- Overflow: wovf <= (winc & wfull) | (wovf & ~wclr_ovf). If a set condition and wclr_ovf occur in the same cycle, set wins.
- Writes while full: wbin and wptr are unchanged; nothing is dropped silently beyond the rejected word, which is flagged by wovf.
- Simultaneous write and read-pointer advance while full: wacc = 0 in that cycle, wfull deasserts next edge, and the write must be retried.
- Reset mid-operation: immediate async clear of all state; wptr = 0 propagates to the read side through its synchroniser.
- wptr changes at most one bit per wclk edge (Gray).

Decomposition:
- Package fifo_pkg holds:
  - function bin2gray(width-generic);
  - function gray2bin(width-generic, XOR prefix from the MSB down);
  - constant for the sync-stage count (2), shared with the read side.
- One sub-module: gray2bin_conv #(W). Purely combinational; converts wq2_rptr to rbin. It is reused by the read-side successor, rptr_empty_level.

Test Plan:
1. Reset with ADD_SIZE=4, wafull_lvl=14, then release -> wptr=0, waddr=0, wfull=0, wafull=0, wlevel=0, wovf=0; assert wrst_n low mid-run -> all outputs clear immediately, without waiting for a clock edge.
2. wq2_rptr=0, 16 consecutive winc -> waddr steps 0..15 then 0. On the 14th edge wlevel=14 and wafull=1. On the 16th edge wlevel=16, wfull=1, wptr=5'b11000.
3. While full, winc=1 for 1 cycle -> wptr stays 5'b11000, wovf=1 next edge. Then wclr_ovf=1 together with winc=1 -> wovf stays 1. Then wclr_ovf alone -> wovf=0.
4. While full, set wq2_rptr=gray(4)=5'b00110 -> next edge wfull=0, wlevel=12, wafull=0. A write in that same cycle is rejected; the following write is accepted, giving wlevel=13.
5. Wrap: stream 40 writes with wq2_rptr following at 2-cycle lag -> wbin wraps 31->0 and wptr goes 5'b10000->5'b00000. wlevel stays in 0..16 and matches the reference model every cycle; wptr changes at most one bit per edge (Gray check).
6. Threshold extremes: wafull_lvl=0 -> wafull=1 from the first edge after reset. wafull_lvl=17 -> wafull never asserts across a full fill.
